// File: rtl/pattern_buffers.sv
// rtl/pattern_buffers.sv - serially loaded bank of pattern buffers plus sequence register
// Seven 216-bit shift chains and one 24-bit chain, read out in parallel by bufp.
module pattern_buffers #(
  parameter int NUM_BUFS  = 7,
  parameter int BUF_BYTES = 27,
  parameter int SEQ_BYTES = 3
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       sin,
  output logic       sout,
  input  logic       ssel,
  input  logic [2:0] saddr,
  input  logic [2:0] bufp,
  output logic [7:0] current_buffer [BUF_BYTES],
  input  logic [4:0] fieldp,
  output logic [7:0] pattern_sequence [SEQ_BYTES]
);

  localparam int BUF_W = BUF_BYTES * 8;
  localparam int SEQ_W = SEQ_BYTES * 8;

  logic [BUF_W-1:0] bufs [NUM_BUFS];
  logic [SEQ_W-1:0] seq;

  logic [BUF_W-1:0] sel_buf;
  logic [7:0]       field_byte;
  logic             shift_msb;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_BUFS; n++) bufs[n] <= '0;
      seq <= '0;
    end else if (ssel) begin
      if (saddr == 3'd7) seq <= {seq[SEQ_W-2:0], sin};
      for (int n = 0; n < NUM_BUFS; n++)
        if (saddr == 3'(n)) bufs[n] <= {bufs[n][BUF_W-2:0], sin};
    end
  end

  // Unmatched pointer values fall through to zero rather than indexing past the array
  always_comb begin
    sel_buf = '0;
    for (int n = 0; n < NUM_BUFS; n++)
      if (bufp == 3'(n)) sel_buf = bufs[n];
  end

  always_comb begin
    field_byte = '0;
    for (int k = 0; k < BUF_BYTES; k++)
      if (fieldp == 5'(k)) field_byte = sel_buf[8*k +: 8];
  end

  always_comb begin
    shift_msb = 1'b0;
    if (saddr == 3'd7) shift_msb = seq[SEQ_W-1];
    for (int n = 0; n < NUM_BUFS; n++)
      if (saddr == 3'(n)) shift_msb = bufs[n][BUF_W-1];
  end

  always_comb begin
    for (int k = 0; k < BUF_BYTES; k++) current_buffer[k] = sel_buf[8*k +: 8];
    for (int k = 0; k < SEQ_BYTES; k++) pattern_sequence[k] = seq[8*k +: 8];
  end

  assign sout = ssel ? shift_msb : ^field_byte;

endmodule

// File: tb/tb_pattern_buffers.sv
// tb/tb_pattern_buffers.sv - scoreboard bench for pattern_buffers
// Stimulus queues expected observations; a monitor pops and compares on each sample event.
module tb_pattern_buffers;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       sin = 1'b0;
  logic       sout;
  logic       ssel = 1'b0;
  logic [2:0] saddr = 3'd0;
  logic [2:0] bufp = 3'd0;
  logic [7:0] current_buffer [27];
  logic [4:0] fieldp = 5'd0;
  logic [7:0] pattern_sequence [3];

  pattern_buffers dut (
    .sclk(sclk), .rst(rst), .sin(sin), .sout(sout), .ssel(ssel), .saddr(saddr),
    .bufp(bufp), .current_buffer(current_buffer), .fieldp(fieldp),
    .pattern_sequence(pattern_sequence)
  );

  typedef struct {
    int         kind;   // 0 current_buffer byte, 1 pattern_sequence byte, 2 sout
    int         idx;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input int kind, input int idx, input logic [7:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      #5 sclk = 1'b1;
      #5 sclk = 1'b0;
    end
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sin = b[i];
      pulse(1);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          0:       act = current_buffer[e.idx];
          1:       act = pattern_sequence[e.idx];
          default: act = {7'd0, sout};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s idx %0d actual %02h expected %02h", e.name, e.idx, act, e.exp);
        end
      end
    end
  end

  initial begin : stim
    // Reset with sclk stopped
    rst = 1'b1;
    #3;
    for (int b = 0; b < 8; b++) begin
      bufp = 3'(b);
      for (int k = 0; k < 27; k++) expect_val(0, k, 8'h00, "reset_cur");
      sample();
    end
    for (int k = 0; k < 3; k++) expect_val(1, k, 8'h00, "reset_seq");
    bufp = 3'd0;
    expect_val(2, 0, 8'h00, "reset_sout_idle");
    sample();
    ssel = 1'b1;
    expect_val(2, 0, 8'h00, "reset_sout_shift");
    sample();
    rst = 1'b0;
    #4;

    // Fill buffer 0 with ones
    saddr = 3'd0; sin = 1'b1; bufp = 3'd0;
    pulse(8);
    expect_val(0, 0, 8'hFF, "fill8_b0");
    expect_val(0, 1, 8'h00, "fill8_b1");
    expect_val(2, 0, 8'h00, "fill8_sout");
    sample();
    pulse(208);
    for (int k = 0; k < 27; k++) expect_val(0, k, 8'hFF, "fill216");
    expect_val(2, 0, 8'h01, "fill216_sout");
    sample();
    for (int b = 1; b < 7; b++) begin
      bufp = 3'(b);
      for (int k = 0; k < 27; k++) expect_val(0, k, 8'h00, "others_zero");
      sample();
    end
    for (int k = 0; k < 3; k++) expect_val(1, k, 8'h00, "seq_zero");
    sample();

    // Sequence register load
    saddr = 3'd7;
    shift_byte(8'hA5);
    shift_byte(8'h3C);
    shift_byte(8'h0F);
    bufp = 3'd0;
    expect_val(1, 0, 8'h0F, "seq0");
    expect_val(1, 1, 8'h3C, "seq1");
    expect_val(1, 2, 8'hA5, "seq2");
    expect_val(2, 0, 8'h01, "seq_sout_msb");
    expect_val(0, 13, 8'hFF, "seq_buf0_kept");
    sample();

    // Buffer 2 byte 5 = 0x07: bits 40..42 come from shifts 174..176
    saddr = 3'd2;
    for (int i = 1; i <= 216; i++) begin
      sin = (i >= 174 && i <= 176);
      pulse(1);
    end
    sin = 1'b0;
    ssel = 1'b0; bufp = 3'd2;
    fieldp = 5'd5;
    expect_val(0, 5, 8'h07, "buf2_b5");
    expect_val(0, 4, 8'h00, "buf2_b4");
    expect_val(0, 6, 8'h00, "buf2_b6");
    expect_val(2, 0, 8'h01, "par_f5");
    sample();
    fieldp = 5'd6;  expect_val(2, 0, 8'h00, "par_f6");  sample();
    fieldp = 5'd30; expect_val(2, 0, 8'h00, "par_f30"); sample();
    fieldp = 5'd5; bufp = 3'd7; expect_val(2, 0, 8'h00, "par_bufp7"); sample();
    fieldp = 5'd0; bufp = 3'd0; expect_val(2, 0, 8'h00, "par_ff_even"); sample();

    // Pointer sweep with wrap
    for (int s = 0; s < 9; s++) begin
      bufp = 3'(s);
      expect_val(0, 0,  (s % 8 == 0) ? 8'hFF : 8'h00, "sweep_b0");
      expect_val(0, 5,  (s % 8 == 0) ? 8'hFF : (s == 2) ? 8'h07 : 8'h00, "sweep_b5");
      expect_val(0, 26, (s % 8 == 0) ? 8'hFF : 8'h00, "sweep_b26");
      sample();
    end

    // Reset mid-load of buffer 4
    ssel = 1'b1; saddr = 3'd4; sin = 1'b1; bufp = 3'd4;
    pulse(100);
    expect_val(0, 11, 8'hFF, "part_b11");
    expect_val(0, 12, 8'h0F, "part_b12");
    expect_val(0, 13, 8'h00, "part_b13");
    sample();
    rst = 1'b1;
    expect_val(0, 0,  8'h00, "midrst_b0");
    expect_val(0, 12, 8'h00, "midrst_b12");
    expect_val(1, 2,  8'h00, "midrst_seq");
    sample();
    rst = 1'b0;
    #3;
    pulse(216);
    for (int k = 0; k < 27; k++) expect_val(0, k, 8'hFF, "reload");
    sample();
    bufp = 3'd0;
    expect_val(0, 0, 8'h00, "reload_buf0_clear");
    sample();

    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
